// File: rtl/seq_hit_logger_if.sv
// rtl/seq_hit_logger_if.sv - read-side valid/ready port of the hit timestamp logger
//
// Purpose: groups the host drain handshake into one bundle.
// Signals:
//   rd_valid  logger -> host  head entry present
//   rd_ready  host -> logger  host takes the head entry this cycle
//   rd_data   logger -> host  timestamp at the FIFO head (TS_W bits)
// Modports: master = logger side, slave = host side.

interface seq_hit_logger_if #(
  parameter int TS_W = 16
);
  logic            rd_valid;
  logic            rd_ready;
  logic [TS_W-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );
endinterface

// File: rtl/seq_hit_logger.sv
// rtl/seq_hit_logger.sv - timestamps sequence-detector hits into a small drainable FIFO
//
// Purpose: samples the detector hit strobe every clock, stamps each hit with a
// free-running timestamp and queues the stamp in a DEPTH-entry FIFO drained by a
// host over a valid/ready port. Keeps saturating hit/drop counters and a sticky
// overflow flag.
// Optional feature macro: HIT_IRQ_EN adds a registered irq output that asserts
// while the FIFO level is at or above THRESH or the overflow flag is set.
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   hit       in   detector strobe, level-sampled every edge
//   clear     in   synchronous clear of FIFO, counters and flags (not the timestamp)
//   rd        if   master side of seq_hit_logger_if (rd_valid/rd_ready/rd_data)
//   level     out  FIFO occupancy 0..DEPTH
//   hit_cnt   out  saturating count of all hits, dropped ones included
//   drop_cnt  out  saturating count of hits lost to a full FIFO
//   ovf       out  sticky: some hit was dropped since reset/clear
//   irq       out  only with HIT_IRQ_EN

module seq_hit_logger #(
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hit,
  input  logic                   clear,
  seq_hit_logger_if.master       rd,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   ovf
`ifdef HIT_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("seq_hit_logger: DEPTH must be a power of 2 and >= 2");
  end
  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("seq_hit_logger: THRESH must be in 1..DEPTH");
  end

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  logic [TS_W-1:0]  rd_data_q, rd_data_d;
`ifdef HIT_IRQ_EN
  logic             irq_q, irq_d;
`endif

  logic pop;
  logic push;
  logic drop;
  logic full;

  always_comb begin
    // A pop is only honoured when an entry is actually presented.
    pop  = (level_q != '0) & rd.rd_ready;
    full = (level_q == FULL_LVL);
    // A full FIFO still accepts a hit when the head leaves in the same cycle.
    push = hit & (~full | pop);
    drop = hit & full & ~pop;

    ts_d       = ts_q + TS_W'(1);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    hit_cnt_d  = hit_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;

    if (clear) begin
      // clear wins over any hit or pop in the same cycle; the hit is not counted.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      hit_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ts_q;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (hit && hit_cnt_q != CNT_MAX) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != CNT_MAX) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
    end

    // rd_data is a register holding the next head, so there is no
    // combinational path from hit to rd_data. When the FIFO goes empty the
    // last value is kept.
    rd_data_d = (level_d != '0) ? mem_d[rd_ptr_d] : rd_data_q;

`ifdef HIT_IRQ_EN
    irq_d = (level_d >= LW'(THRESH)) | ovf_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hit_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
`ifdef HIT_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      ts_q       <= ts_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hit_cnt_q  <= hit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
`ifdef HIT_IRQ_EN
      irq_q      <= irq_d;
`endif
    end
  end

  assign rd.rd_valid = (level_q != '0);
  assign rd.rd_data  = rd_data_q;
  assign level       = level_q;
  assign hit_cnt     = hit_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign ovf         = ovf_q;
`ifdef HIT_IRQ_EN
  assign irq         = irq_q;
`endif

endmodule

// File: tb/tb_seq_hit_logger.sv
// tb/tb_seq_hit_logger.sv - scoreboard bench for seq_hit_logger

module tb_seq_hit_logger;

  localparam int TS_W   = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int THRESH = 3;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int TS_MOD = 1 << TS_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             hit = 1'b0;
  logic             clear = 1'b0;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             ovf;
`ifdef HIT_IRQ_EN
  logic             irq;
`endif

  seq_hit_logger_if #(.TS_W(TS_W)) rd_if ();

  seq_hit_logger #(
    .TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .THRESH(THRESH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hit      (hit),
    .clear    (clear),
    .rd       (rd_if),
    .level    (level),
    .hit_cnt  (hit_cnt),
    .drop_cnt (drop_cnt),
    .ovf      (ovf)
`ifdef HIT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: timestamp, occupancy, counters; exp_q holds queued stamps.
  int m_ts, m_level, m_hit, m_drop;
  bit m_ovf, m_irq;
  int exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_level = 0; m_hit = 0; m_drop = 0; m_ovf = 0; m_irq = 0;
    exp_q.delete();
  endtask

  // Effect of one rising edge, from the block's rules.
  task automatic model_step();
    int stamp;
    bit pop;
    if (!reset_n) begin
      model_reset();
      return;
    end
    stamp = m_ts;
    m_ts  = (m_ts + 1) % TS_MOD;
    if (clear) begin
      exp_q.delete();
      m_level = 0; m_hit = 0; m_drop = 0; m_ovf = 0; m_irq = 0;
      return;
    end
    pop = (m_level > 0) && rd_if.rd_ready;
    if (pop) m_level--;  // the head itself was taken off exp_q by the monitor
    if (hit) begin
      if (m_hit < CMAX) m_hit++;
      if (m_level < DEPTH) begin
        exp_q.push_back(stamp);
        m_level++;
      end else begin
        m_ovf = 1;
        if (m_drop < CMAX) m_drop++;
      end
    end
    m_irq = (m_level >= THRESH) || m_ovf;
  endtask

  // Inputs change 1 time unit after the edge and are held to the next edge.
  task automatic cycle(bit h, bit r, bit c);
    hit = h;
    rd_if.rd_ready = r;
    clear = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: checks state on the falling edge; consumes the expected head when
  // a handshake will complete on the next rising edge.
  always @(negedge clk) begin
    chk("level", int'(level), m_level);
    chk("rd_valid", int'(rd_if.rd_valid), int'(m_level != 0));
    chk("hit_cnt", int'(hit_cnt), m_hit);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("ovf", int'(ovf), int'(m_ovf));
`ifdef HIT_IRQ_EN
    chk("irq", int'(irq), int'(m_irq));
`endif
    if (rd_if.rd_valid) begin
      if (exp_q.size() == 0) chk("head_expected", 0, 1);
      else                   chk("rd_data", int'(rd_if.rd_data), exp_q[0]);
    end
    if (rd_if.rd_valid && rd_if.rd_ready && !clear && reset_n && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  initial begin
    rd_if.rd_ready = 1'b0;
    model_reset();
    repeat (3) cycle(0, 0, 0);
    reset_n = 1'b1;

    // Mid-run asynchronous reset with two entries held.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("pre_reset_level", int'(level), 2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_valid", int'(rd_if.rd_valid), 0);
    chk("async_rst_data", int'(rd_if.rd_data), 0);
    chk("async_rst_hit_cnt", int'(hit_cnt), 0);
    chk("async_rst_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    cycle(0, 0, 0);
    reset_n = 1'b1;

    // Hits at ts=5 and ts=7, then drain.
    repeat (5) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("t2_level", int'(level), 2);
    chk("t2_head", int'(rd_if.rd_data), 5);
    cycle(0, 1, 0);
    chk("t2_second", int'(rd_if.rd_data), 7);
    cycle(0, 1, 0);
    chk("t2_empty", int'(rd_if.rd_valid), 0);
    chk("t2_hit_cnt", int'(hit_cnt), 2);

    // Six hits into a four-entry FIFO.
    cycle(0, 0, 1);
    repeat (6) cycle(1, 0, 0);
    chk("t3_level", int'(level), 4);
    chk("t3_drop", int'(drop_cnt), 2);
    chk("t3_hits", int'(hit_cnt), 6);
    chk("t3_ovf", int'(ovf), 1);

    // Full, hit together with pop: no drop, level stays full.
    cycle(1, 1, 0);
    chk("t4_level", int'(level), 4);
    chk("t4_drop", int'(drop_cnt), 2);
    repeat (5) cycle(0, 1, 0);

    // clear together with a hit.
    cycle(1, 0, 1);
    chk("t5_clear_level", int'(level), 0);
    chk("t5_clear_hits", int'(hit_cnt), 0);

    // Timestamp wrap: 14 then 3 cycles later 1.
    for (int k = 0; k < 2 * TS_MOD && m_ts != 14; k++) cycle(0, 0, 0);
    chk("t5_ts_aligned", m_ts, 14);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("t5_head", int'(rd_if.rd_data), 14);
    cycle(0, 1, 0);
    chk("t5_wrapped", int'(rd_if.rd_data), 1);
    cycle(0, 1, 0);

`ifdef HIT_IRQ_EN
    // irq tracks the level threshold.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("t6_irq_lvl2", int'(irq), 0);
    cycle(1, 0, 0);
    chk("t6_irq_lvl3", int'(irq), 1);
    cycle(0, 1, 0);
    chk("t6_irq_drop", int'(irq), 0);
    repeat (3) cycle(0, 1, 0);
`endif

    // Randomized traffic, including saturation of the 4-bit counters.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 3);
    repeat (DEPTH + 2) cycle(0, 1, 0);
    chk("final_empty", int'(rd_if.rd_valid), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
